// File: rtl/ma_sample_feeder.sv
// ma_sample_feeder: paced sample source for the moving-average filter.
// Samples arrive over a valid/ready stream, are buffered in a small FIFO,
// and are presented on din with single-cycle data_refresh strobes spaced
// at least gap_cycles idle cycles apart. Optional repeat mode re-issues the
// last sample when the FIFO runs dry.
module ma_sample_feeder #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          repeat_en,
  input  logic [GAP_W-1:0]              gap_cycles,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  output logic [DATA_W-1:0]             din,
  output logic                          data_refresh,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    repeat_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic [1:0]        r_state;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_primed;
  logic [DATA_W-1:0] r_din;
  logic              r_refresh;
  logic [7:0]        r_repeat_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_run;
  logic w_pop;
  logic w_rep;
  logic w_fire;

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign s_ready = enable && !w_full && !flush;
  assign w_push  = s_valid && s_ready;

  // An issue slot exists only in RUN while enabled and not flushing.
  assign w_run  = enable && !flush && (r_state == ST_RUN);
  assign w_pop  = w_run && !w_empty;
  assign w_rep  = w_run && w_empty && repeat_en && r_primed;
  assign w_fire = w_pop || w_rep;

  assign din          = r_din;
  assign data_refresh = r_refresh;
  assign fifo_level   = r_level;
  assign repeat_cnt   = r_repeat_cnt;

  // FIFO storage write port.
  // NOTE: the sample memory has no reset; the pointers and level alone
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy; flush empties it ahead of any push/pop.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Pacing FSM: issues pulses from the FIFO head (or repeats) and times gaps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= '0;
      r_primed     <= 1'b0;
      r_din        <= '0;
      r_refresh    <= 1'b0;
      r_repeat_cnt <= '0;
    end else if (flush) begin
      r_state      <= enable ? ST_RUN : ST_IDLE;
      r_gap_cnt    <= '0;
      r_primed     <= 1'b0;
      r_refresh    <= 1'b0;
      r_repeat_cnt <= '0;
    end else if (!enable) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_refresh <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_refresh <= 1'b0;
          r_gap_cnt <= '0;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          r_refresh <= w_fire;
          if (w_pop) begin
            r_din    <= r_mem[r_rd_ptr];
            r_primed <= 1'b1;
          end
          if (w_rep && (r_repeat_cnt != 8'hFF))
            r_repeat_cnt <= r_repeat_cnt + 8'd1;
          // gap_cycles is captured only at the moment a pulse is issued.
          if (w_fire && (gap_cycles != '0)) begin
            r_gap_cnt <= gap_cycles;
            r_state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_refresh <= 1'b0;
          r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          if (r_gap_cnt == GAP_W'(1)) r_state <= ST_RUN;
        end
        default: begin
          r_refresh <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ma_sample_feeder.sv
// Directed testbench for ma_sample_feeder with hand-computed expectations.
module tb_ma_sample_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        repeat_en;
  logic [15:0] gap_cycles;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [15:0] din;
  logic        data_refresh;
  logic [3:0]  fifo_level;
  logic [7:0]  repeat_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  int pk_level;
  int pc[$];
  logic [15:0] pd[$];

  always #5 clk = ~clk;

  ma_sample_feeder #(.DATA_W(16), .FIFO_DEPTH(8), .GAP_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .repeat_en    (repeat_en),
    .gap_cycles   (gap_cycles),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .din          (din),
    .data_refresh (data_refresh),
    .fifo_level   (fifo_level),
    .repeat_cnt   (repeat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge, sample 1 time unit later, log pulses and peak level.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (data_refresh) begin
      pc.push_back(cyc);
      pd.push_back(din);
    end
    if (int'(fifo_level) > pk_level) pk_level = int'(fifo_level);
  endtask

  task automatic clear_log();
    cyc = 0;
    pk_level = 0;
    pc.delete();
    pd.delete();
  endtask

  initial begin
    int k;
    logic acc;

    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; repeat_en = 1'b0;
    gap_cycles = 16'd0; s_valid = 1'b0; s_data = 16'd0;
    clear_log();

    // Reset state
    tick(); tick();
    check("rst_din", din, 16'h0000);
    check("rst_refresh", data_refresh, 1'b0);
    check("rst_level", fifo_level, 4'd0);
    check("rst_repcnt", repeat_cnt, 8'd0);
    check("rst_ready_dis", s_ready, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic pass-through, gap 0
    enable = 1'b1;
    tick();
    check("pt_ready", s_ready, 1'b1);
    s_valid = 1'b1; s_data = 16'h0001;
    tick();
    check("pt_lvl0", fifo_level, 4'd1);
    check("pt_ref0", data_refresh, 1'b0);
    s_data = 16'h8000;
    tick();
    check("pt_ref1", data_refresh, 1'b1);
    check("pt_din1", din, 16'h0001);
    s_data = 16'h7FFF;
    tick();
    check("pt_ref2", data_refresh, 1'b1);
    check("pt_din2", din, 16'h8000);
    s_valid = 1'b0;
    tick();
    check("pt_ref3", data_refresh, 1'b1);
    check("pt_din3", din, 16'h7FFF);
    check("pt_lvl3", fifo_level, 4'd0);
    tick();
    check("pt_ref_end", data_refresh, 1'b0);

    // Pacing, gap 3: pushes at ticks 1..5, pulses at 2,6,10,14,18
    gap_cycles = 16'd3;
    clear_log();
    for (int i = 0; i < 25; i++) begin
      s_valid = (i < 5);
      s_data  = 16'h0010 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    check("pace_cnt", pc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < pc.size()) begin
        check($sformatf("pace_cyc%0d", i), pc[i], 2 + 4 * i);
        check($sformatf("pace_din%0d", i), pd[i], 16'h0010 + 16'(i));
      end
    end
    check("pace_peak", pk_level, 4);

    // Full/backpressure, gap 100, 10 samples held on s_valid
    gap_cycles = 16'd100;
    clear_log();
    k = 0;
    for (int i = 0; i < 1000; i++) begin
      s_valid = (k < 10);
      s_data  = 16'h0A00 + 16'(k);
      acc = s_valid && s_ready;
      tick();
      if (acc) k++;
      if (cyc == 50) begin
        check("bp_level_full", fifo_level, 4'd8);
        check("bp_ready_low", s_ready, 1'b0);
      end
    end
    s_valid = 1'b0;
    check("bp_accepted", k, 10);
    check("bp_cnt", pc.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < pc.size()) begin
        check($sformatf("bp_din%0d", i), pd[i], 16'h0A00 + 16'(i));
        check($sformatf("bp_cyc%0d", i), pc[i], 2 + 101 * i);
      end
    end
    check("bp_peak", pk_level, 8);

    // Repeat mode, gap 2, one sample
    gap_cycles = 16'd2;
    repeat_en = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("rep_flush_cnt", repeat_cnt, 8'd0);
    clear_log();
    s_valid = 1'b1; s_data = 16'h1234;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("rep_cnt_pulses", pc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < pc.size()) begin
        check($sformatf("rep_cyc%0d", i), pc[i], 2 + 3 * i);
        check($sformatf("rep_din%0d", i), pd[i], 16'h1234);
      end
    end
    check("rep_repcnt3", repeat_cnt, 8'd3);
    // Saturation with gap 0
    gap_cycles = 16'd0;
    for (int i = 0; i < 300; i++) tick();
    check("rep_sat", repeat_cnt, 8'd255);
    check("rep_sat_din", din, 16'h1234);
    check("rep_sat_ref", data_refresh, 1'b1);
    // Flush clears counter, keeps din
    repeat_en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_repcnt", repeat_cnt, 8'd0);
    check("fl_ref", data_refresh, 1'b0);
    check("fl_din", din, 16'h1234);
    // repeat_en=0: single pulse only
    gap_cycles = 16'd2;
    clear_log();
    s_valid = 1'b1; s_data = 16'h5678;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("norep_cnt", pc.size(), 1);
    check("norep_din", din, 16'h5678);

    // Enable/flush: 3 queued samples, disabled
    gap_cycles = 16'd50;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h00C0 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    check("en_lvl_q", fifo_level, 4'd3);
    enable = 1'b0;
    clear_log();
    for (int i = 0; i < 60; i++) tick();
    check("dis_pulses", pc.size(), 0);
    check("dis_level", fifo_level, 4'd3);
    check("dis_din", din, 16'h00C0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("dfl_level", fifo_level, 4'd0);
    check("dfl_din", din, 16'h00C0);
    repeat_en = 1'b1;
    enable = 1'b1;
    clear_log();
    for (int i = 0; i < 10; i++) tick();
    check("reen_pulses", pc.size(), 0);

    // Sync reset mid-gap
    repeat_en = 1'b0;
    gap_cycles = 16'd20;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h00D0 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    tick(); tick();
    check("gap_lvl", fifo_level, 4'd2);
    check("gap_din", din, 16'h00D0);
    rst_n = 1'b0;
    tick();
    check("mr_din", din, 16'h0000);
    check("mr_ref", data_refresh, 1'b0);
    check("mr_level", fifo_level, 4'd0);
    check("mr_repcnt", repeat_cnt, 8'd0);
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 16'h0BAD;
    tick();
    s_valid = 1'b0;
    check("ar_ref0", data_refresh, 1'b0);
    tick();
    check("ar_ref1", data_refresh, 1'b1);
    check("ar_din", din, 16'h0BAD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ma_sample_feeder.md
Name: ma_sample_feeder

Overview:
Upstream pacing source for the moving-average filter's sample interface. It accepts signed 16-bit samples over a valid/ready stream and buffers them in a small FIFO. It then presents them on din with single-cycle data_refresh pulses, spaced at least gap_cycles apart. An optional repeat mode re-issues the last sample when the FIFO runs dry, so the filter sees a steady sample rate.

Parameters:
DATA_W, 16, sample width (signed, two's complement)
FIFO_DEPTH, 8, FIFO entries; power of two, >= 2
GAP_W, 16, width of gap_cycles and the pacing counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  block enable; low = no pulses, FIFO retained
flush  in  1  synchronous clear of FIFO, primed flag and repeat_cnt
repeat_en  in  1  re-issue last sample on an empty slot
gap_cycles  in  GAP_W  idle cycles required between pulses
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream ready = enable && !full && !flush (combinational)
s_data  in  DATA_W  upstream sample
din  out  DATA_W  sample to filter, registered, held between pulses
data_refresh  out  1  one-cycle sample strobe, registered
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
repeat_cnt  out  8  saturating count of repeated (re-issued) samples

Behaviour:
- Reset (rst_n=0 at a clk edge): din=0, data_refresh=0, fifo_level=0, repeat_cnt=0, state=IDLE, gap_cnt=0, primed=0.
- Push: s_valid && s_ready at edge → write s_data, level+1. Pop: issued by the FSM, level-1. A push and a pop in the same edge leave the level unchanged. No push is possible when full, because s_ready is low.
- FSM states: IDLE, RUN, GAP.
  - IDLE: data_refresh=0. enable=1 → RUN with gap_cnt=0.
  - RUN, FIFO non-empty: pop the head, din<=head, data_refresh<=1, primed<=1.
    - gap_cycles==0 → stay in RUN.
    - else gap_cnt<=gap_cycles and → GAP.
  - RUN, FIFO empty, repeat_en=1, primed=1: data_refresh<=1, din unchanged, repeat_cnt+1 (saturate at 255), same gap handling as a normal pulse.
  - RUN, FIFO empty, otherwise: no pulse, stay in RUN.
  - GAP: gap_cnt decrements each cycle; on gap_cnt==1 → RUN.
- Pulse spacing: a pulse at cycle t allows the next pulse no earlier than t+gap_cycles+1. gap_cycles is sampled only when a pulse is issued; changes mid-gap take effect after the next pulse.
- Latency: a sample accepted at edge t into an empty FIFO, with the FSM in RUN, produces data_refresh high and din=sample after edge t+1. FIFO read is first-word fall-through internally.
- data_refresh is high for exactly one cycle per issued sample and is never high in two consecutive cycles unless gap_cycles==0.
- enable=0 in any state → IDLE at the next edge, no pulse that cycle, FIFO and din retained. Re-enable resumes with gap_cnt=0.
- Flush (priority over push/pop): FIFO emptied, level=0, primed=0, repeat_cnt=0, data_refresh=0, din kept. The FSM goes to RUN if enabled, else IDLE.
- Reset mid-operation: all state returns to reset values at that edge. An in-flight pulse is dropped.
- Pointers wrap modulo FIFO_DEPTH. Full = level==FIFO_DEPTH; empty = level==0.
- The data path is a pure pass-through: no arithmetic on samples, sign preserved bit-exact.

Test Plan:
- Basic pass-through: enable=1, gap_cycles=0; push 0x0001, 0x8000, 0x7FFF back-to-back → three consecutive data_refresh pulses with din=0x0001, 0x8000, 0x7FFF, the first one edge after the first accept.
- Pacing: gap_cycles=3, push 5 samples at once → pulses at cycles t, t+4, t+8, t+12, t+16; fifo_level peaks at 4.
- Full/backpressure: gap_cycles=100, hold s_valid with 10 samples → s_ready drops after the level reaches 8 (one pulse popped); remaining samples accepted one per pulse in order; no loss or duplication.
- Repeat mode: repeat_en=1, gap_cycles=2, push one sample 0x1234 → pulses every 3 cycles with din=0x1234; repeat_cnt increments per extra pulse and saturates at 255. With repeat_en=0 → single pulse only.
- Enable/flush: disable with 3 samples queued → no pulses, level holds at 3. Flush → level=0, repeat_cnt=0, din unchanged. Re-enable with an empty FIFO → no pulse.
- Sync reset mid-gap: rst_n low for 1 edge during GAP → all outputs at reset values next cycle, no pulse. Next push after reset → pulse one edge later.
